// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture with 7-step restoring duty divider
module pwm_capture #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] period_out,
  output logic [6:0]       duty_out,
  output logic             valid,
  output logic             busy,
  output logic             timeout,
  output logic             ovr
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_DIV  = 1'b1;
  localparam int               DW      = WIDTH + 7;
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl;
  logic                   lvl_d;
  logic                   rise;
  logic [WIDTH-1:0]       cnt_per;
  logic [WIDTH-1:0]       cnt_hi;
  logic [WIDTH-1:0]       per_cap;
  logic [0:0]             state;
  logic [2:0]             step;
  logic [DW-1:0]          rem;
  logic [DW-1:0]          dsh;
  logic [DW-1:0]          rem_nxt;
  logic [5:0]             quo;
  logic                   qbit;
  logic                   armed;
  logic                   fired;
  logic                   start;
  logic                   drop;
  logic                   to_fire;

  assign lvl     = sync_q[SYNC_STAGES-1];
  assign rise    = lvl & ~lvl_d;
  assign busy    = (state == ST_DIV);
  assign start   = rise & armed & ~busy;
  assign drop    = rise & armed & busy;
  // An edge in the saturation cycle wins; fired keeps a static line from re-triggering
  assign to_fire = (cnt_per == CNT_MAX) & ~fired & ~rise & ~busy;
  assign qbit    = (rem >= dsh);
  assign rem_nxt = qbit ? (rem - dsh) : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      lvl_d   <= 1'b0;
      cnt_per <= '0;
      cnt_hi  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      lvl_d  <= lvl;
      if (rise) begin
        cnt_per <= WIDTH'(1);
        cnt_hi  <= WIDTH'(1);
      end else begin
        if (cnt_per != CNT_MAX) cnt_per <= cnt_per + WIDTH'(1);
        if (lvl && cnt_hi != CNT_MAX) cnt_hi <= cnt_hi + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      step       <= '0;
      rem        <= '0;
      dsh        <= '0;
      quo        <= '0;
      per_cap    <= '0;
      armed      <= 1'b0;
      fired      <= 1'b0;
      period_out <= '0;
      duty_out   <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise) begin
        armed <= 1'b1;
        fired <= 1'b0;
      end
      if (start) begin
        // Quotient never exceeds 100, so a divisor pre-shifted by 6 covers all 7 bits
        state   <= ST_DIV;
        step    <= '0;
        rem     <= DW'(cnt_hi) * DW'(100);
        dsh     <= DW'(cnt_per) << 6;
        quo     <= '0;
        per_cap <= cnt_per;
      end else if (busy) begin
        rem  <= rem_nxt;
        dsh  <= dsh >> 1;
        quo  <= {quo[4:0], qbit};
        step <= step + 3'd1;
        if (step == 3'd6) begin
          state      <= ST_IDLE;
          period_out <= per_cap;
          duty_out   <= {quo, qbit};
          valid      <= 1'b1;
          timeout    <= 1'b0;
        end
      end else if (to_fire) begin
        period_out <= '0;
        duty_out   <= lvl ? 7'd100 : 7'd0;
        valid      <= 1'b1;
        timeout    <= 1'b1;
        armed      <= 1'b0;
        fired      <= 1'b1;
      end
      if (drop) ovr <= 1'b1;
      else if (clr_ovr) ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture against an edge-list reference model
module tb_pwm_capture;

  localparam int WIDTH = 12;
  localparam int SYNC  = 2;
  localparam int SAT   = 4095;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic             clr_ovr = 1'b0;
  logic [WIDTH-1:0] period_out;
  logic [6:0]       duty_out;
  logic             valid;
  logic             busy;
  logic             timeout;
  logic             ovr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_cnt = 0;

  int obs_per[$];
  int obs_duty[$];
  int obs_cyc[$];
  int obs_to[$];

  int rise_q[$];
  int per_q[$];
  int hi_q[$];
  int exp_per[$];
  int exp_duty[$];
  int exp_drops;

  pwm_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .clr_ovr    (clr_ovr),
    .period_out (period_out),
    .duty_out   (duty_out),
    .valid      (valid),
    .busy       (busy),
    .timeout    (timeout),
    .ovr        (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        obs_per.push_back(int'(period_out));
        obs_duty.push_back(int'(duty_out));
        obs_cyc.push_back(cyc);
        obs_to.push_back(int'(timeout));
      end
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pwm_in = 1'b0;
    clr_ovr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    rise_q.delete();
    per_q.delete();
    hi_q.delete();
  endtask

  task automatic drive_period(input int p, input int h);
    rise_q.push_back(cyc);
    per_q.push_back(p);
    hi_q.push_back(h);
    pwm_in = 1'b1;
    repeat (h) tick();
    pwm_in = 1'b0;
    repeat (p - h) tick();
  endtask

  task automatic final_rise();
    rise_q.push_back(cyc);
    pwm_in = 1'b1;
  endtask

  // First edge arms; each later edge measures the preceding period unless it lands
  // within 7 cycles of the last accepted edge, in which case it is dropped.
  function automatic void build_model();
    int  last;
    int  p;
    bit  have;
    exp_per.delete();
    exp_duty.delete();
    exp_drops = 0;
    have = 0;
    last = 0;
    for (int i = 1; i < rise_q.size(); i++) begin
      p = (per_q[i-1] > SAT) ? SAT : per_q[i-1];
      if (have && (rise_q[i] - last) < 8) begin
        exp_drops++;
      end else begin
        have = 1;
        last = rise_q[i];
        exp_per.push_back(p);
        exp_duty.push_back(hi_q[i-1] * 100 / p);
      end
    end
  endfunction

  task automatic test_reset();
    int b;
    int n;
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({period_out, duty_out, valid, busy, timeout, ovr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got per=%0d duty=%0d v=%b b=%b to=%b ovr=%b want all 0",
               period_out, duty_out, valid, busy, timeout, ovr);
    end
    do_reset();
    drive_period(20, 10);
    final_rise();
    n = 0;
    while (!busy && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_div_start: busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_abort: busy=%b valid=%b want 0 0", busy, valid);
    end
    repeat (2) tick();
    b = obs_per.size();
    rst_n = 1'b1;
    repeat (20) tick();
    checks++;
    if (obs_per.size() != b) begin
      failures++;
      $display("FAIL reset_no_valid: valids=%0d want 0", obs_per.size() - b);
    end
  endtask

  task automatic test_basic();
    int b;
    int bb;
    do_reset();
    b = obs_per.size();
    bb = busy_cnt;
    drive_period(100, 25);
    drive_period(100, 25);
    final_rise();
    repeat (20) tick();
    build_model();
    checks++;
    if (obs_per.size() - b != exp_per.size()) begin
      failures++;
      $display("FAIL basic_count: got %0d want %0d", obs_per.size() - b, exp_per.size());
    end
    for (int i = 0; i < exp_per.size() && b + i < obs_per.size(); i++) begin
      checks++;
      if (obs_per[b+i] != exp_per[i] || obs_duty[b+i] != exp_duty[i]) begin
        failures++;
        $display("FAIL basic_meas%0d: got %0d/%0d want %0d/%0d", i,
                 obs_per[b+i], obs_duty[b+i], exp_per[i], exp_duty[i]);
      end
    end
    if (obs_per.size() - b >= 2) begin
      checks++;
      if (obs_cyc[b] != rise_q[1] + SYNC + 8) begin
        failures++;
        $display("FAIL basic_latency: valid at %0d want %0d", obs_cyc[b], rise_q[1] + SYNC + 8);
      end
      checks++;
      if (obs_cyc[b+1] - obs_cyc[b] != 100) begin
        failures++;
        $display("FAIL basic_spacing: got %0d want 100", obs_cyc[b+1] - obs_cyc[b]);
      end
    end
    checks++;
    if (busy_cnt - bb != 14) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d want 14", busy_cnt - bb);
    end
  endtask

  task automatic test_ratio();
    int b;
    do_reset();
    b = obs_per.size();
    repeat (4) drive_period(7, 3);
    final_rise();
    repeat (20) tick();
    build_model();
    checks++;
    if (obs_per.size() - b != exp_per.size()) begin
      failures++;
      $display("FAIL ratio7_count: got %0d want %0d", obs_per.size() - b, exp_per.size());
    end
    for (int i = 0; i < exp_per.size() && b + i < obs_per.size(); i++) begin
      checks++;
      if (obs_per[b+i] != exp_per[i] || obs_duty[b+i] != exp_duty[i]) begin
        failures++;
        $display("FAIL ratio7_meas%0d: got %0d/%0d want %0d/%0d", i,
                 obs_per[b+i], obs_duty[b+i], exp_per[i], exp_duty[i]);
      end
    end
    do_reset();
    b = obs_per.size();
    drive_period(4095, 4094);
    final_rise();
    repeat (20) tick();
    build_model();
    checks++;
    if (obs_per.size() - b != 1 || exp_per.size() != 1) begin
      failures++;
      $display("FAIL ratio4095_count: got %0d want %0d", obs_per.size() - b, exp_per.size());
    end else begin
      checks++;
      if (obs_per[b] != exp_per[0] || obs_duty[b] != exp_duty[0]) begin
        failures++;
        $display("FAIL ratio4095_meas: got %0d/%0d want %0d/%0d",
                 obs_per[b], obs_duty[b], exp_per[0], exp_duty[0]);
      end
    end
  endtask

  task automatic test_timeout_high();
    int b;
    int r;
    do_reset();
    b = obs_per.size();
    drive_period(50, 20);
    final_rise();
    r = rise_q[rise_q.size()-1];
    repeat (4096 + 30) tick();
    checks++;
    if (obs_per.size() - b != 2) begin
      failures++;
      $display("FAIL to_high_count: got %0d want 2", obs_per.size() - b);
    end else begin
      checks++;
      if (obs_per[b] != 50 || obs_duty[b] != 40 || obs_to[b] != 0) begin
        failures++;
        $display("FAIL to_high_meas: got %0d/%0d to=%0d want 50/40 to=0",
                 obs_per[b], obs_duty[b], obs_to[b]);
      end
      checks++;
      if (obs_per[b+1] != 0 || obs_duty[b+1] != 100 || obs_to[b+1] != 1) begin
        failures++;
        $display("FAIL to_high_value: got %0d/%0d to=%0d want 0/100 to=1",
                 obs_per[b+1], obs_duty[b+1], obs_to[b+1]);
      end
      checks++;
      if (obs_cyc[b+1] != r + SYNC + SAT + 1) begin
        failures++;
        $display("FAIL to_high_time: got %0d want %0d", obs_cyc[b+1], r + SYNC + SAT + 1);
      end
    end
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL to_high_flag: timeout=%b want 1", timeout);
    end
    b = obs_per.size();
    pwm_in = 1'b0;
    repeat (5) tick();
    rise_q.delete();
    per_q.delete();
    hi_q.delete();
    drive_period(30, 10);
    checks++;
    if (timeout !== 1'b1 || obs_per.size() != b) begin
      failures++;
      $display("FAIL to_rearm_only: timeout=%b valids=%0d want 1 0", timeout, obs_per.size() - b);
    end
    final_rise();
    repeat (20) tick();
    checks++;
    if (obs_per.size() - b != 1) begin
      failures++;
      $display("FAIL to_recover_count: got %0d want 1", obs_per.size() - b);
    end else begin
      checks++;
      if (obs_per[b] != 30 || obs_duty[b] != 33 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL to_recover_meas: got %0d/%0d to=%b want 30/33 to=0",
                 obs_per[b], obs_duty[b], timeout);
      end
    end
  endtask

  task automatic test_timeout_low();
    int b;
    do_reset();
    b = obs_per.size();
    drive_period(40, 10);
    drive_period(40, 10);
    repeat (4096 + 10) tick();
    checks++;
    if (obs_per.size() - b != 2) begin
      failures++;
      $display("FAIL to_low_count: got %0d want 2", obs_per.size() - b);
    end else begin
      checks++;
      if (obs_per[b] != 40 || obs_duty[b] != 25) begin
        failures++;
        $display("FAIL to_low_meas: got %0d/%0d want 40/25", obs_per[b], obs_duty[b]);
      end
      checks++;
      if (obs_per[b+1] != 0 || obs_duty[b+1] != 0 || obs_to[b+1] != 1 ||
          obs_cyc[b+1] != rise_q[1] + SYNC + SAT + 1) begin
        failures++;
        $display("FAIL to_low_value: got %0d/%0d to=%0d at %0d want 0/0 to=1 at %0d",
                 obs_per[b+1], obs_duty[b+1], obs_to[b+1], obs_cyc[b+1],
                 rise_q[1] + SYNC + SAT + 1);
      end
    end
    do_reset();
    b = obs_per.size();
    repeat (4200) tick();
    checks++;
    if (obs_per.size() - b != 1) begin
      failures++;
      $display("FAIL to_unarmed_count: got %0d want 1", obs_per.size() - b);
    end else begin
      checks++;
      if (obs_per[b] != 0 || obs_duty[b] != 0 || timeout !== 1'b1) begin
        failures++;
        $display("FAIL to_unarmed_value: got %0d/%0d to=%b want 0/0 to=1",
                 obs_per[b], obs_duty[b], timeout);
      end
    end
  endtask

  task automatic test_overrun();
    int b;
    do_reset();
    b = obs_per.size();
    repeat (3) drive_period(4, 2);
    final_rise();
    repeat (20) tick();
    build_model();
    checks++;
    if (obs_per.size() - b != exp_per.size()) begin
      failures++;
      $display("FAIL ovr_count: got %0d want %0d", obs_per.size() - b, exp_per.size());
    end
    for (int i = 0; i < exp_per.size() && b + i < obs_per.size(); i++) begin
      checks++;
      if (obs_per[b+i] != exp_per[i] || obs_duty[b+i] != exp_duty[i]) begin
        failures++;
        $display("FAIL ovr_meas%0d: got %0d/%0d want %0d/%0d", i,
                 obs_per[b+i], obs_duty[b+i], exp_per[i], exp_duty[i]);
      end
    end
    checks++;
    if (ovr !== (exp_drops > 0)) begin
      failures++;
      $display("FAIL ovr_set: ovr=%b want %b", ovr, exp_drops > 0);
    end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    checks++;
    if (ovr !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear: ovr=%b want 0", ovr);
    end
    do_reset();
    fork
      begin
        repeat (3) drive_period(4, 2);
        final_rise();
      end
      begin
        repeat (2 * 4 + SYNC) tick();
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
      end
    join
    repeat (20) tick();
    checks++;
    if (ovr !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set_wins: ovr=%b want 1", ovr);
    end
  endtask

  task automatic test_loopback();
    int b;
    do_reset();
    b = obs_per.size();
    repeat (5) drive_period(200, 74);
    final_rise();
    repeat (20) tick();
    checks++;
    if (obs_per.size() - b != 5) begin
      failures++;
      $display("FAIL loop_count: got %0d want 5", obs_per.size() - b);
    end
    for (int i = b; i < obs_per.size(); i++) begin
      checks++;
      if (obs_per[i] != 200 || obs_duty[i] != 37 ||
          (i > b && obs_cyc[i] - obs_cyc[i-1] != 200)) begin
        failures++;
        $display("FAIL loop_meas%0d: got %0d/%0d want 200/37 spacing 200", i - b,
                 obs_per[i], obs_duty[i]);
      end
    end
  endtask

  task automatic test_random();
    int b;
    int p;
    int h;
    do_reset();
    b = obs_per.size();
    for (int k = 0; k < 40; k++) begin
      p = $urandom_range(60, 2);
      h = $urandom_range(p - 1, 1);
      drive_period(p, h);
    end
    final_rise();
    repeat (20) tick();
    build_model();
    checks++;
    if (obs_per.size() - b != exp_per.size()) begin
      failures++;
      $display("FAIL rand_count: got %0d want %0d", obs_per.size() - b, exp_per.size());
    end
    for (int i = 0; i < exp_per.size() && b + i < obs_per.size(); i++) begin
      checks++;
      if (obs_per[b+i] != exp_per[i] || obs_duty[b+i] != exp_duty[i]) begin
        failures++;
        $display("FAIL rand_meas%0d: got %0d/%0d want %0d/%0d", i,
                 obs_per[b+i], obs_duty[b+i], exp_per[i], exp_duty[i]);
      end
    end
    checks++;
    if (ovr !== (exp_drops > 0)) begin
      failures++;
      $display("FAIL rand_ovr: ovr=%b want %b", ovr, exp_drops > 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ratio();
    test_timeout_high();
    test_timeout_low();
    test_overrun();
    test_loopback();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
